// File: rtl/traffic_light_monitor_if.sv
// Lamp inputs, fault clear and supervisor status bundled between the monitor and its environment.
interface traffic_light_monitor_if #(
   parameter int unsigned CNT_W = 8
);
   logic             R_LED;
   logic             Y_LED;
   logic             G_LED;
   logic             Clear_Fault;
   logic [1:0]       Phase;
   logic [CNT_W-1:0] Phase_Cycles;
   logic [15:0]      Cycle_Count;
   logic             Fault;
   logic [2:0]       Fault_Code;
   logic             Force_Red;

   // Environment side: drives lamps and clear, observes status
   modport master (
      output R_LED, Y_LED, G_LED, Clear_Fault,
      input  Phase, Phase_Cycles, Cycle_Count, Fault, Fault_Code, Force_Red
   );

   // Monitor side
   modport slave (
      input  R_LED, Y_LED, G_LED, Clear_Fault,
      output Phase, Phase_Cycles, Cycle_Count, Fault, Fault_Code, Force_Red
   );
endinterface

// File: rtl/traffic_light_monitor.sv
// Supervisor for a R->G->Y->R traffic light: checks sequence and dwell limits, counts completed
// sequences, latches a sticky fault code and requests a forced red in INIT/FAULT.
module traffic_light_monitor #(
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned R_MAX    = 64,
   parameter int unsigned G_MAX    = 64,
   parameter int unsigned Y_MIN    = 2,
   parameter int unsigned Y_MAX    = 16,
   parameter int unsigned DARK_MAX = 1
) (
   input  logic                    Clock,
   input  logic                    Reset_n,
   traffic_light_monitor_if.slave  io_bus
);

   typedef enum logic [2:0] {StInit, StRed, StGreen, StYellow, StFault} state_e;

   localparam logic [2:0] CodeConflict = 3'd1;
   localparam logic [2:0] CodeDark     = 3'd2;
   localparam logic [2:0] CodeIllegal  = 3'd3;
   localparam logic [2:0] CodeTimeout  = 3'd4;
   localparam logic [2:0] CodeYShort   = 3'd5;

   state_e           r_state, w_state_nxt, w_succ_state;
   logic [2:0]       r_in_q;
   logic [CNT_W-1:0] r_phase_cycles, w_pc_nxt;
   logic [CNT_W-1:0] r_dark_cnt, w_dark_nxt;
   logic [15:0]      r_cycle_count, w_cc_nxt;
   logic [2:0]       r_fault_code, w_code_nxt, w_code_det;
   logic [1:0]       r_phase, w_phase_nxt;
   logic             r_fault, r_force_red;

   logic             w_is_red, w_is_yel, w_is_grn, w_dark, w_conflict;
   logic             w_same, w_succ;
   logic [CNT_W:0]   w_pc_inc, w_dark_inc;
   logic [31:0]      w_limit;

   // Register the raw lamp pattern {R,Y,G}; decisions act on it one edge later
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_in_q <= 3'b000;
      end else begin
         r_in_q <= {io_bus.R_LED, io_bus.Y_LED, io_bus.G_LED};
      end
   end

   assign w_is_red   = (r_in_q == 3'b100);
   assign w_is_yel   = (r_in_q == 3'b010);
   assign w_is_grn   = (r_in_q == 3'b001);
   assign w_dark     = (r_in_q == 3'b000);
   assign w_conflict = ~(w_is_red | w_is_yel | w_is_grn | w_dark);

   assign w_pc_inc   = {1'b0, r_phase_cycles} + (CNT_W + 1)'(1);
   assign w_dark_inc = {1'b0, r_dark_cnt} + (CNT_W + 1)'(1);

   // Per-phase dwell limit, same-colour match and the legal successor colour
   always_comb begin
      w_limit      = '1;
      w_same       = 1'b0;
      w_succ       = 1'b0;
      w_succ_state = StInit;
      unique case (r_state)
         StRed: begin
            w_limit      = R_MAX;
            w_same       = w_is_red;
            w_succ       = w_is_grn;
            w_succ_state = StGreen;
         end
         StGreen: begin
            w_limit      = G_MAX;
            w_same       = w_is_grn;
            w_succ       = w_is_yel;
            w_succ_state = StYellow;
         end
         StYellow: begin
            w_limit      = Y_MAX;
            w_same       = w_is_yel;
            w_succ       = w_is_red;
            w_succ_state = StRed;
         end
         default: ;
      endcase
   end

   // Next-state, counters and fault detection; branches are exclusive so code priority holds
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_phase_cycles;
      w_dark_nxt  = r_dark_cnt;
      w_cc_nxt    = r_cycle_count;
      w_code_nxt  = r_fault_code;
      w_code_det  = 3'd0;
      unique case (r_state)
         StInit: begin
            if (w_conflict) begin
               w_code_det = CodeConflict;
            end else if (w_is_red) begin
               w_state_nxt = StRed;
               w_pc_nxt    = CNT_W'(1);
               w_dark_nxt  = '0;
            end
         end
         StRed, StGreen, StYellow: begin
            if (w_conflict) begin
               w_code_det = CodeConflict;
            end else if (w_dark) begin
               // Phase_Cycles holds across a tolerated gap
               if (32'(w_dark_inc) > DARK_MAX) begin
                  w_code_det = CodeDark;
               end else begin
                  w_dark_nxt = w_dark_inc[CNT_W-1:0];
               end
            end else if (w_same) begin
               if (32'(w_pc_inc) > w_limit) begin
                  w_code_det = CodeTimeout;
               end else begin
                  w_pc_nxt   = w_pc_inc[CNT_W] ? '1 : w_pc_inc[CNT_W-1:0];
                  w_dark_nxt = '0;
               end
            end else if (w_succ) begin
               if ((r_state == StYellow) && (32'(r_phase_cycles) < Y_MIN)) begin
                  w_code_det = CodeYShort;
               end else begin
                  w_state_nxt = w_succ_state;
                  w_pc_nxt    = CNT_W'(1);
                  w_dark_nxt  = '0;
                  if (r_state == StYellow) begin
                     w_cc_nxt = r_cycle_count + 16'd1;
                  end
               end
            end else begin
               w_code_det = CodeIllegal;
            end
         end
         StFault: begin
            if (io_bus.Clear_Fault) begin
               w_state_nxt = StInit;
               w_code_nxt  = 3'd0;
            end
         end
         default: begin
            w_state_nxt = StInit;
         end
      endcase
      if (w_code_det != 3'd0) begin
         w_state_nxt = StFault;
         w_code_nxt  = w_code_det;
         w_pc_nxt    = '0;
         w_dark_nxt  = '0;
      end
   end

   // Phase number reported for the upcoming state
   always_comb begin
      w_phase_nxt = 2'd0;
      unique case (w_state_nxt)
         StRed:    w_phase_nxt = 2'd1;
         StGreen:  w_phase_nxt = 2'd2;
         StYellow: w_phase_nxt = 2'd3;
         default:  w_phase_nxt = 2'd0;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state        <= StInit;
         r_phase_cycles <= '0;
         r_dark_cnt     <= '0;
         r_cycle_count  <= '0;
         r_fault_code   <= 3'd0;
         r_fault        <= 1'b0;
         r_phase        <= 2'd0;
         r_force_red    <= 1'b1;
      end else begin
         r_state        <= w_state_nxt;
         r_phase_cycles <= w_pc_nxt;
         r_dark_cnt     <= w_dark_nxt;
         r_cycle_count  <= w_cc_nxt;
         r_fault_code   <= w_code_nxt;
         r_fault        <= (w_state_nxt == StFault);
         r_phase        <= w_phase_nxt;
         r_force_red    <= (w_phase_nxt == 2'd0);
      end
   end

   assign io_bus.Phase        = r_phase;
   assign io_bus.Phase_Cycles = r_phase_cycles;
   assign io_bus.Cycle_Count  = r_cycle_count;
   assign io_bus.Fault        = r_fault;
   assign io_bus.Fault_Code   = r_fault_code;
   assign io_bus.Force_Red    = r_force_red;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios with literal expectations plus
// randomized lamp streams compared every cycle against a behavioural model.
module tb_traffic_light_monitor;

   localparam int Y_MIN    = 2;
   localparam int DARK_MAX = 1;

   localparam logic [2:0] PatR = 3'b100;
   localparam logic [2:0] PatY = 3'b010;
   localparam logic [2:0] PatG = 3'b001;
   localparam logic [2:0] PatD = 3'b000;

   logic Clock;
   logic Reset_n;

   int n_checks;
   int n_pass;

   traffic_light_monitor_if #(.CNT_W(8)) bus ();

   traffic_light_monitor #(
      .CNT_W    (8),
      .R_MAX    (64),
      .G_MAX    (64),
      .Y_MIN    (2),
      .Y_MAX    (16),
      .DARK_MAX (1)
   ) dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .io_bus  (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // ---------------- behavioural model ----------------
   // phase: 0 none, 1 red, 2 green, 3 yellow; pattern acted on is the one seen one edge earlier
   int         m_phase, m_cyc, m_dark, m_count, m_code;
   bit         m_fault;
   logic [2:0] m_pat;
   int         t_phase, t_cyc, t_dark, t_count, t_code, t_col, t_ones;
   bit         t_fault;
   int         limit [4] = '{0, 64, 64, 16};

   function automatic int colour_of(input logic [2:0] p);
      if (p == PatR) return 1;
      if (p == PatG) return 2;
      if (p == PatY) return 3;
      return 0;
   endfunction

   function automatic int succ(input int p);
      return (p == 3) ? 1 : p + 1;
   endfunction

   always @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         m_phase <= 0; m_cyc <= 0; m_dark <= 0; m_count <= 0; m_code <= 0;
         m_fault <= 1'b0; m_pat <= PatD;
      end else begin
         t_phase = m_phase; t_cyc = m_cyc; t_dark = m_dark; t_count = m_count;
         t_code = m_code; t_fault = m_fault;
         t_col = colour_of(m_pat);
         t_ones = $countones(m_pat);
         if (m_fault) begin
            if (bus.Clear_Fault) begin
               t_fault = 1'b0;
               t_code  = 0;
            end
         end else begin
            int c;
            c = 0;
            if (t_ones > 1) c = 1;
            else if (m_phase == 0) begin
               if (t_col == 1) begin t_phase = 1; t_cyc = 1; end
            end else if (t_ones == 0) begin
               if (m_dark + 1 > DARK_MAX) c = 2; else t_dark = m_dark + 1;
            end else if (t_col == m_phase) begin
               if (m_cyc + 1 > limit[m_phase]) c = 4;
               else begin t_cyc = (m_cyc + 1 > 255) ? 255 : m_cyc + 1; t_dark = 0; end
            end else if (t_col == succ(m_phase)) begin
               if (m_phase == 3 && m_cyc < Y_MIN) c = 5;
               else begin
                  if (m_phase == 3) t_count = (m_count + 1) % 65536;
                  t_phase = t_col; t_cyc = 1; t_dark = 0;
               end
            end else c = 3;
            if (c != 0) begin
               t_fault = 1'b1; t_code = c; t_phase = 0; t_cyc = 0; t_dark = 0;
            end
         end
         m_phase <= t_phase; m_cyc <= t_cyc; m_dark <= t_dark; m_count <= t_count;
         m_code <= t_code; m_fault <= t_fault;
         m_pat <= {bus.R_LED, bus.Y_LED, bus.G_LED};
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Compare every output against the model on each falling edge out of reset
   always @(negedge Clock) begin
      if (Reset_n === 1'b1) begin
         check("phase", int'(bus.Phase), m_phase);
         check("phase_cycles", int'(bus.Phase_Cycles), m_cyc);
         check("cycle_count", int'(bus.Cycle_Count), m_count);
         check("fault", int'(bus.Fault), int'(m_fault));
         check("fault_code", int'(bus.Fault_Code), m_code);
         check("force_red", int'(bus.Force_Red), (m_phase == 0) ? 1 : 0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic lamps(input logic [2:0] pat, input int n);
      {bus.R_LED, bus.Y_LED, bus.G_LED} = pat;
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic pulse_clear();
      bus.Clear_Fault = 1'b1;
      @(posedge Clock);
      #1;
      bus.Clear_Fault = 1'b0;
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      {bus.R_LED, bus.Y_LED, bus.G_LED} = PatD;
      bus.Clear_Fault = 1'b0;
      repeat (3) @(posedge Clock);
      #1;
      Reset_n = 1'b1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_phase"}, int'(bus.Phase), 0);
      check({tag, "_pc"}, int'(bus.Phase_Cycles), 0);
      check({tag, "_cc"}, int'(bus.Cycle_Count), 0);
      check({tag, "_fault"}, int'(bus.Fault), 0);
      check({tag, "_code"}, int'(bus.Fault_Code), 0);
      check({tag, "_force"}, int'(bus.Force_Red), 1);
   endtask

   function automatic logic [2:0] pat_of(input int c);
      if (c == 1) return PatR;
      if (c == 2) return PatG;
      return PatY;
   endfunction

   initial begin
      int cur, dwell, r;
      n_checks = 0;
      n_pass   = 0;
      Reset_n  = 1'b0;
      bus.Clear_Fault = 1'b0;
      do_reset();
      check_reset_values("reset");

      // Legal sequence R10 G10 Y4 R
      lamps(PatR, 10);
      check("seq_red_phase", int'(bus.Phase), 1);
      check("seq_red_pc", int'(bus.Phase_Cycles), 9);
      check("seq_red_force", int'(bus.Force_Red), 0);
      lamps(PatG, 10);
      check("seq_grn_phase", int'(bus.Phase), 2);
      lamps(PatY, 4);
      check("seq_yel_phase", int'(bus.Phase), 3);
      check("seq_yel_pc", int'(bus.Phase_Cycles), 3);
      lamps(PatR, 2);
      check("seq_back_red", int'(bus.Phase), 1);
      check("seq_cc", int'(bus.Cycle_Count), 1);

      // Conflict while green
      lamps(PatR, 2);
      lamps(PatG, 3);
      lamps(3'b101, 1);
      lamps(PatG, 1);
      check("conf_fault", int'(bus.Fault), 1);
      check("conf_code", int'(bus.Fault_Code), 1);
      check("conf_force", int'(bus.Force_Red), 1);
      lamps(PatG, 5);
      check("conf_sticky", int'(bus.Fault_Code), 1);
      pulse_clear();
      check("clr_fault", int'(bus.Fault), 0);
      check("clr_cc", int'(bus.Cycle_Count), 1);

      // Illegal R->Y, then clear and re-enter red
      lamps(PatR, 3);
      lamps(PatY, 2);
      check("illegal_code", int'(bus.Fault_Code), 3);
      pulse_clear();
      check("illegal_clr", int'(bus.Fault), 0);
      check("illegal_cc", int'(bus.Cycle_Count), 1);
      lamps(PatR, 2);
      check("reenter_red", int'(bus.Phase), 1);

      // Dark gap of one cycle is tolerated, two is not
      lamps(PatR, 5);
      lamps(PatD, 1);
      lamps(PatR, 3);
      check("dark1_pc", int'(bus.Phase_Cycles), 9);
      check("dark1_fault", int'(bus.Fault), 0);
      lamps(PatD, 2);
      lamps(PatR, 1);
      check("dark2_code", int'(bus.Fault_Code), 2);

      // Green timeout
      do_reset();
      lamps(PatR, 3);
      lamps(PatG, 65);
      check("tmo_pc64", int'(bus.Phase_Cycles), 64);
      check("tmo_nofault", int'(bus.Fault), 0);
      lamps(PatG, 1);
      check("tmo_code", int'(bus.Fault_Code), 4);

      // Yellow too short
      do_reset();
      lamps(PatR, 3);
      lamps(PatG, 3);
      lamps(PatY, 1);
      lamps(PatR, 2);
      check("yshort_code", int'(bus.Fault_Code), 5);
      check("yshort_cc", int'(bus.Cycle_Count), 0);

      // Asynchronous reset in the middle of yellow
      do_reset();
      lamps(PatR, 3);
      lamps(PatG, 3);
      lamps(PatY, 3);
      check("async_pre_phase", int'(bus.Phase), 3);
      #3;
      Reset_n = 1'b0;
      #1;
      check_reset_values("async");

      // Randomized lamp streams
      do_reset();
      cur = 1;
      for (int k = 0; k < 400; k++) begin
         r = int'($urandom_range(0, 99));
         if (m_fault && r < 40) begin
            pulse_clear();
         end else if (r < 5) begin
            lamps(PatD, int'($urandom_range(1, 2)));
         end else if (r < 9) begin
            lamps(3'($urandom_range(0, 7)), 1);
         end else if (r < 11) begin
            pulse_clear();
         end else begin
            dwell = (cur == 3) ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 20));
            if (r > 97) dwell = 70;
            lamps(pat_of(cur), dwell);
            cur = succ(cur);
         end
      end
      lamps(PatD, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
